demux_1to2_buf: RTL and testbench

// - Inverse of the pipeline's 2:1 operand/result mux: steers one input stream to one of two destinations.
// - Input word A with select bit sel goes to destination 0 when sel=0 and to destination 1 when sel=1.
// - Buffers up to 2 words in order, with valid/ready handshakes on every side.
// - Sits between the execute/memory stage and two consumers, e.g. the register-file writeback and the memory-store path.

---
 rtl/demux_1to2_buf.sv | 123 ++++++++++++
 tb/tb_demux_1to2_buf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf
//   Steers one valid/ready input stream to one of two destinations. Each word
//   A is tagged with sel (0 -> C0, 1 -> C1). A 2-entry in-order buffer sits
//   between the input and the outputs. Routing is strict head-of-line: only
//   the oldest word is offered, on the side named by its sel.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; A is the data, sel the destination
//   out0_valid/out0_ready  destination 0 handshake, data on C0 (0 when idle)
//   out1_valid/out1_ready  destination 1 handshake, data on C1 (0 when idle)
//   cnt0, cnt1             words delivered per destination, wrapping

module demux_1to2_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic             sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] C0,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] C1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // head_q is always the oldest word; tail_q is only meaningful at occupancy 2.
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           new_entry;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic has_head;
    logic push;
    logic pop0;
    logic pop1;
    logic pop;

    // Everything offered outward depends only on registered state.
    always_comb begin
        has_head   = (occ_q != 2'd0);
        in_ready   = (occ_q != 2'd2);
        out0_valid = has_head & ~head_q.sel;
        out1_valid = has_head & head_q.sel;
        C0         = out0_valid ? head_q.data : '0;
        C1         = out1_valid ? head_q.data : '0;
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

    always_comb begin
        new_entry.sel  = sel;
        new_entry.data = A;
        push = in_valid & in_ready;
        pop0 = out0_valid & out0_ready;
        pop1 = out1_valid & out1_ready;
        pop  = pop0 | pop1;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;

        if (push && pop) begin
            // Only reachable at occupancy 1: the new word replaces the head.
            head_d = new_entry;
        end else if (pop) begin
            head_d = tail_q;
            tail_d = '0;
            occ_d  = occ_q - 2'd1;
        end else if (push) begin
            if (occ_q == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
            occ_d = occ_q + 2'd1;
        end

        if (pop0) begin
            cnt0_d = cnt0_q + CntOne;
        end
        if (pop1) begin
            cnt1_d = cnt1_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Self-checking bench for demux_1to2_buf. Inputs change just after the
// falling edge; outputs are sampled there, well away from the rising edge.
// A queue models the buffer contents: accepted words are pushed when driven
// and popped when the model expects the head to be delivered.

module tb_demux_1to2_buf;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic             sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] C0;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] C1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    demux_1to2_buf #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .sel       (sel),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .C0        (C0),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .C1        (C1),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             valid;
        logic             sel;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t            sb[$];
    int               checks = 0;
    int               passes = 0;
    logic [CNT_W-1:0] exp_cnt0 = '0;
    logic [CNT_W-1:0] exp_cnt1 = '0;

    // One clock cycle of stimulus. Returns whether the model expects a
    // delivery this cycle, what the DUT shows, and what the model expects.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] a, input logic s,
                         input logic r0, input logic r1,
                         output logic popped, output word_t got, output word_t exp);
        int pre_size;
        in_valid   = iv;
        A          = a;
        sel        = s;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        pre_size   = sb.size();
        popped     = (pre_size > 0) && (sb[0].sel ? r1 : r0);
        got.valid  = out0_valid | out1_valid;
        got.sel    = out1_valid;
        got.data   = out1_valid ? C1 : C0;
        exp        = 'x;
        if (popped) begin
            exp = sb.pop_front();
            if (exp.sel) exp_cnt1++;
            else exp_cnt0++;
        end
        if (iv && pre_size < 2) sb.push_back(word_t'{valid: 1'b1, sel: s, data: a});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        A          = '0;
        sel        = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt0 = '0;
        exp_cnt1 = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({in_ready, out0_valid, out1_valid} !== 3'b100)
            $display("FAIL reset_flags: got %b want 100", {in_ready, out0_valid, out1_valid});
        else passes++;
        checks++;
        if ({C0, C1} !== '0) $display("FAIL reset_data: got C0=%h C1=%h want 0", C0, C1);
        else passes++;
        checks++;
        if ({cnt0, cnt1} !== '0) $display("FAIL reset_cnt: got %h/%h want 0/0", cnt0, cnt1);
        else passes++;
    endtask

    task automatic test_dest0();
        logic pp;
        word_t got, exp;
        drive(1'b1, 32'hF0F0F0F0, 1'b0, 1'b1, 1'b0, pp, got, exp);
        checks++;
        if ({out0_valid, out1_valid, C0, C1} !== {2'b10, 32'hF0F0F0F0, 32'h0})
            $display("FAIL dest0_out: got v=%b%b C0=%h C1=%h want v=10 C0=f0f0f0f0 C1=0",
                     out0_valid, out1_valid, C0, C1);
        else passes++;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, pp, got, exp);
        checks++;
        if (!pp || got !== exp) $display("FAIL dest0_pop: got %h want %h", got, exp);
        else passes++;
        checks++;
        if (cnt0 !== 16'd1) $display("FAIL dest0_cnt: got %0d want 1", cnt0);
        else passes++;
    endtask

    task automatic test_stall();
        logic pp;
        word_t got, exp;
        drive(1'b1, 32'h80000001, 1'b1, 1'b0, 1'b0, pp, got, exp);
        checks++;
        if ({out1_valid, out0_valid, C1} !== {2'b10, 32'h80000001})
            $display("FAIL stall_out: got v1=%b v0=%b C1=%h want 1 0 80000001",
                     out1_valid, out0_valid, C1);
        else passes++;
        drive(1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0, pp, got, exp);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_full: in_ready got %b want 0", in_ready);
        else passes++;
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, pp, got, exp);
        checks++;
        if ({out1_valid, C1} !== {1'b1, 32'h80000001})
            $display("FAIL stall_hold: got v1=%b C1=%h want 1 80000001", out1_valid, C1);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1, pp, got, exp);
            checks++;
            if (!pp || got !== exp) $display("FAIL stall_pop%0d: got %h want %h", i, got, exp);
            else passes++;
        end
        checks++;
        if (cnt1 !== 16'd2 || cnt1 !== exp_cnt1)
            $display("FAIL stall_cnt1: got %0d want 2", cnt1);
        else passes++;
    endtask

    task automatic test_hol();
        logic pp;
        word_t got, exp;
        drive(1'b1, 32'h11, 1'b1, 1'b1, 1'b0, pp, got, exp);
        drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, pp, got, exp);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, pp, got, exp);
        checks++;
        if ({out0_valid, out1_valid, C0} !== {2'b01, 32'h0})
            $display("FAIL hol_block: got v0=%b v1=%b C0=%h want 0 1 0", out0_valid, out1_valid, C0);
        else passes++;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, pp, got, exp);
        checks++;
        if (!pp || got !== word_t'{valid: 1'b1, sel: 1'b1, data: 32'h11} || got !== exp)
            $display("FAIL hol_first: got %h want %h", got, exp);
        else passes++;
        checks++;
        if ({out0_valid, C0, C1} !== {1'b1, 32'h22, 32'h0})
            $display("FAIL hol_second: got v0=%b C0=%h C1=%h want 1 22 0", out0_valid, C0, C1);
        else passes++;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, pp, got, exp);
        checks++;
        if (!pp || got !== exp) $display("FAIL hol_pop: got %h want %h", got, exp);
        else passes++;
    endtask

    task automatic test_stream();
        logic pp;
        word_t got, exp;
        logic [CNT_W-1:0] base0, base1;
        base0 = cnt0;
        base1 = cnt1;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, pp, got, exp);
        for (int i = 1; i <= 8; i++) begin
            drive(i < 8, 32'hA000_0000 + i, i[0], 1'b1, 1'b1, pp, got, exp);
            checks++;
            if (!pp || got !== exp || got.data !== 32'hA000_0000 + i - 1)
                $display("FAIL stream_word%0d: got %h want %h", i - 1, got, exp);
            else passes++;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, in_ready);
            else passes++;
        end
        checks++;
        if (cnt0 !== base0 + 16'd4 || cnt1 !== base1 + 16'd4 || cnt0 !== exp_cnt0)
            $display("FAIL stream_cnt: got %0d/%0d want %0d/%0d",
                     cnt0, cnt1, base0 + 16'd4, base1 + 16'd4);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic pp;
        word_t got, exp;
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, pp, got, exp);
        drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, pp, got, exp);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL midrst_full: in_ready got %b want 0", in_ready);
        else passes++;
        apply_reset();
        checks++;
        if ({in_ready, out0_valid, out1_valid, C0, C1} !== {3'b100, 64'h0})
            $display("FAIL midrst_out: got rdy=%b v=%b%b C0=%h C1=%h want 1 00 0 0",
                     in_ready, out0_valid, out1_valid, C0, C1);
        else passes++;
        checks++;
        if ({cnt0, cnt1} !== '0) $display("FAIL midrst_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
        else passes++;
    endtask

    task automatic test_wrap();
        logic pp;
        word_t got, exp;
        int bad = 0;
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, pp, got, exp);
        for (int i = 1; i <= 65535; i++) begin
            drive(1'b1, i, 1'b0, 1'b1, 1'b0, pp, got, exp);
            if (!pp || got !== exp) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL wrap_stream: got %0d bad words want 0", bad);
        else passes++;
        checks++;
        if (cnt0 !== 16'hFFFF || cnt0 !== exp_cnt0)
            $display("FAIL wrap_max: cnt0 got %h want ffff", cnt0);
        else passes++;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, pp, got, exp);
        checks++;
        if (!pp || got !== exp) $display("FAIL wrap_last: got %h want %h", got, exp);
        else passes++;
        checks++;
        if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000)
            $display("FAIL wrap_zero: got %h/%h want 0000/0000", cnt0, cnt1);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_dest0();
        test_stall();
        test_hol();
        test_stream();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
